// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port between I-cache (port 0) and D-cache (port 1).
// Latency: req seen in IDLE -> ram_req next cycle; ram_ready -> done next cycle; 3-cycle minimum.
// Backpressure: the owner is held off until ram_ready or timeout; the other port waits in req_i.
module ram_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        grant_o,
    output logic [1:0]        done_o,
    output logic [1:0]        err_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_ready,
    input  logic [DATA_W-1:0] ram_in
);

    localparam int             CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit             TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              last, last_nxt;
    logic              owner, owner_nxt;
    logic              winner;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [1:0]        grant_nxt, done_nxt, err_nxt;
    logic [DATA_W-1:0] rdata_nxt;
    logic              req_nxt, we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= 1'b1;
            owner       <= 1'b0;
            cnt         <= '0;
            grant_o     <= '0;
            done_o      <= '0;
            err_o       <= '0;
            rdata_o     <= '0;
            ram_req     <= 1'b0;
            ram_we      <= 1'b0;
            ram_address <= '0;
            ram_wdata   <= '0;
        end else begin
            state       <= state_nxt;
            last        <= last_nxt;
            owner       <= owner_nxt;
            cnt         <= cnt_nxt;
            grant_o     <= grant_nxt;
            done_o      <= done_nxt;
            err_o       <= err_nxt;
            rdata_o     <= rdata_nxt;
            ram_req     <= req_nxt;
            ram_we      <= we_nxt;
            ram_address <= addr_nxt;
            ram_wdata   <= wdata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        grant_nxt = grant_o;
        done_nxt  = '0;
        err_nxt   = '0;
        rdata_nxt = '0;
        req_nxt   = ram_req;
        we_nxt    = ram_we;
        addr_nxt  = ram_address;
        wdata_nxt = ram_wdata;
        // On contention the port that was not served last time wins.
        winner    = (req_i == 2'b11) ? ~last : req_i[1];

        case (state)
            IDLE: begin
                if (|req_i) begin
                    owner_nxt = winner;
                    last_nxt  = winner;
                    grant_nxt = winner ? 2'b10 : 2'b01;
                    req_nxt   = 1'b1;
                    we_nxt    = we_i[winner];
                    addr_nxt  = winner ? addr1_i : addr0_i;
                    wdata_nxt = winner ? wdata1_i : wdata0_i;
                    cnt_nxt   = '0;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (ram_ready) begin
                    rdata_nxt        = ram_we ? '0 : ram_in;
                    done_nxt[owner]  = 1'b1;
                    req_nxt          = 1'b0;
                    state_nxt        = RESPOND;
                end else if (TIMEOUT_EN && cnt == CNT_LAST) begin
                    err_nxt[owner]   = 1'b1;
                    done_nxt[owner]  = 1'b1;
                    req_nxt          = 1'b0;
                    state_nxt        = RESPOND;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RESPOND: begin
                grant_nxt = '0;
                we_nxt    = 1'b0;
                addr_nxt  = '0;
                wdata_nxt = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_ram_arbiter;

    localparam int TMO = 4;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req, we;
    logic [31:0] addr0, addr1;
    logic [63:0] wdata0, wdata1, rin;
    logic        rdy;

    logic [1:0]  grant_o, done_o, err_o;
    logic [63:0] rdata_o;
    logic        ram_req, ram_we;
    logic [31:0] ram_address;
    logic [63:0] ram_wdata;

    int checks = 0;
    int errors = 0;

    ram_arbiter #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_i(req), .we_i(we),
        .addr0_i(addr0), .addr1_i(addr1),
        .wdata0_i(wdata0), .wdata1_i(wdata1),
        .grant_o(grant_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
        .ram_req(ram_req), .ram_we(ram_we), .ram_address(ram_address), .ram_wdata(ram_wdata),
        .ram_ready(rdy), .ram_in(rin)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one outstanding transaction, described by a phase
    // (free / RAM busy / reporting) and how long the RAM has been waited on.
    int          m_phase, m_wait, m_owner, m_last;
    logic [1:0]  e_grant, e_done, e_err;
    logic [63:0] e_rdata, e_wdata;
    logic        e_req, e_we;
    logic [31:0] e_addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_wait = 0; m_owner = 0; m_last = 1;
            e_grant = 0; e_done = 0; e_err = 0; e_rdata = 0;
            e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
        end else begin
            e_done = 0; e_err = 0; e_rdata = 0;
            if (m_phase == 0) begin
                if (req != 2'b00) begin
                    m_owner = (req == 2'b11) ? 1 - m_last : (req[1] ? 1 : 0);
                    m_last  = m_owner;
                    e_grant = 2'(1 << m_owner);
                    e_req   = 1;
                    e_we    = we[m_owner];
                    e_addr  = (m_owner == 1) ? addr1 : addr0;
                    e_wdata = (m_owner == 1) ? wdata1 : wdata0;
                    m_wait  = 0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (rdy) begin
                    e_done[m_owner] = 1'b1;
                    e_rdata = e_we ? 64'h0 : rin;
                    e_req   = 0;
                    m_phase = 2;
                end else if (TMO != 0 && m_wait + 1 == TMO) begin
                    e_done[m_owner] = 1'b1;
                    e_err[m_owner]  = 1'b1;
                    e_req   = 0;
                    m_phase = 2;
                end else begin
                    m_wait++;
                end
            end else begin
                e_grant = 0;
                m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("grant", grant_o, e_grant);
        chk("grant_onehot", ($countones(grant_o) <= 1), 1);
        chk("done", done_o, e_done);
        chk("err", err_o, e_err);
        chk("ram_req", ram_req, e_req);
        if (e_done != 0) chk("rdata", rdata_o, e_rdata);
        if (e_req) begin
            chk("ram_we", ram_we, e_we);
            chk("ram_address", ram_address, e_addr);
            chk("ram_wdata", ram_wdata, e_wdata);
        end
    end

    task automatic do_reset();
        req = 0; we = 0; rdy = 0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 20 && !ram_req; i++) tick();
        chk(name, ram_req, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_g;
        logic [1:0] got_done, got_err;
        int         n_hi;

        rst_n = 1'b1; req = 0; we = 0; rdy = 0; rin = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_ram_req", ram_req, 1'b0);
        chk("rst_done", done_o, 2'b00);
        chk("rst_address", ram_address, 32'h0);
        rst_n = 1'b1;

        // Port 0 refill read, RAM answers in the third ISSUE cycle.
        req = 2'b01; we = 2'b00; addr0 = 32'h1000;
        tick();
        chk("t1_ram_req", ram_req, 1'b1);
        chk("t1_address", ram_address, 32'h1000);
        tick();
        tick();
        rdy = 1; rin = 64'hDEADBEEF_CAFEF00D;
        tick();
        rdy = 0; rin = 64'h0;
        chk("t1_done", done_o, 2'b01);
        chk("t1_rdata", rdata_o, 64'hDEADBEEF_CAFEF00D);
        chk("t1_err", err_o, 2'b00);
        chk("t1_grant_held", grant_o, 2'b01);
        req = 2'b00;
        tick();
        chk("t1_done_clear", done_o, 2'b00);
        chk("t1_grant_clear", grant_o, 2'b00);

        // Both ports keep requesting: grants alternate starting with port 0.
        do_reset();
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            wait_req("t2_wait");
            chk("t2_grant", grant_o, exp_g);
            rdy = 1; rin = {$urandom(), $urandom()};
            tick();
            rdy = 0;
            chk("t2_done", done_o, exp_g);
            req = req & ~done_o;
            tick();
            req = (k < 3) ? 2'b11 : 2'b00;
        end

        // Port 1 write-back; inputs scrambled after grant must not leak through.
        do_reset();
        req = 2'b10; we = 2'b10; addr1 = 32'h2040; wdata1 = {16{4'h5}};
        rin = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t3_we", ram_we, 1'b1);
            chk("t3_address", ram_address, 32'h2040);
            chk("t3_wdata", ram_wdata, {16{4'h5}});
            addr1 = $urandom(); wdata1 = {$urandom(), $urandom()};
            tick();
        end
        rdy = 1;
        tick();
        rdy = 0;
        chk("t3_done", done_o, 2'b10);
        chk("t3_rdata", rdata_o, 64'h0);
        req = 2'b00; we = 2'b00;
        tick();

        // RAM never answers: timeout after TMO cycles of ram_req.
        do_reset();
        req = 2'b01; addr0 = 32'h80;
        n_hi = 0; got_done = 0; got_err = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ram_req) n_hi++;
            if (done_o != 0) begin
                got_done = done_o;
                got_err  = err_o;
                req = 2'b00;
            end
        end
        chk("t4_req_cycles", n_hi, TMO);
        chk("t4_done", got_done, 2'b01);
        chk("t4_err", got_err, 2'b01);
        chk("t4_idle_grant", grant_o, 2'b00);

        // Reset in the middle of ISSUE.
        do_reset();
        req = 2'b01; addr0 = 32'h500;
        tick();
        chk("t5_ram_req_before", ram_req, 1'b1);
        rst_n = 1'b0;
        req = 2'b11;
        #1;
        chk("t5_ram_req_async", ram_req, 1'b0);
        chk("t5_grant_async", grant_o, 2'b00);
        tick();
        tick();
        chk("t5_no_done", done_o, 2'b00);
        rst_n = 1'b1;
        wait_req("t5_wait");
        chk("t5_first_grant", grant_o, 2'b01);
        rdy = 1;
        tick();
        rdy = 0;
        req = req & ~done_o;
        wait_req("t5_wait2");
        chk("t5_second_grant", grant_o, 2'b10);
        rdy = 1;
        tick();
        rdy = 0;
        req = 2'b00;
        tick();

        // Stray ram_ready while idle, then request dropped and address changed mid-ISSUE.
        do_reset();
        rdy = 1;
        tick();
        rdy = 0;
        chk("t6_stray_done", done_o, 2'b00);
        chk("t6_stray_req", ram_req, 1'b0);
        req = 2'b01; addr0 = 32'h3000;
        tick();
        chk("t6_address0", ram_address, 32'h3000);
        req = 2'b00; addr0 = 32'h4444;
        tick();
        chk("t6_address1", ram_address, 32'h3000);
        chk("t6_grant", grant_o, 2'b01);
        rdy = 1;
        tick();
        rdy = 0;
        chk("t6_done", done_o, 2'b01);
        tick();

        // Randomized traffic; requesters hold req until their done.
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (req[p] && done_o[p]) begin
                    req[p] = 1'b0;
                end else if (!req[p] && $urandom_range(2) == 0) begin
                    req[p] = 1'b1;
                    we[p]  = 1'($urandom_range(1));
                    if (p == 0) begin addr0 = $urandom(); wdata0 = {$urandom(), $urandom()}; end
                    else        begin addr1 = $urandom(); wdata1 = {$urandom(), $urandom()}; end
                end else if (req[p] && $urandom_range(3) == 0) begin
                    if (p == 0) begin addr0 = $urandom(); wdata0 = {$urandom(), $urandom()}; end
                    else        begin addr1 = $urandom(); wdata1 = {$urandom(), $urandom()}; end
                end
            end
            rdy = ($urandom_range(3) == 0);
            rin = {$urandom(), $urandom()};
            tick();
        end
        req = 2'b00; rdy = 0;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
